// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch stage.
//   XLEN         - datapath/address width
//   NOP_INSTR    - addi x0,x0,0; presented to IF/ID whenever no real instruction is available
//   INSTR_BYTES  - PC increment per fetched word
//   fetch_entry_t - one fetch-buffer slot {pc, instr, filled}
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// fetch_if: bundles the fetch stage's pipeline-control, instruction-memory and IF/ID signals.
//   master modport - the fetch unit (drives imem_req/imem_addr and the IF/ID outputs)
//   slave modport  - the environment (hazard unit, EX redirect, instruction memory, IF/ID register)
//   stall, redirect, redirect_pc          : pipeline control into fetch
//   imem_req, imem_addr                   : request to instruction memory
//   imem_gnt, imem_rvalid, imem_rdata     : memory grant and in-order response
//   if_valid, if_pc, if_instr, flush_ifid : towards the IF/ID register
interface fetch_if #(
  parameter int XLEN = fetch_pkg::XLEN
);
  import fetch_pkg::*;

  logic            stall;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instr;
  logic            flush_ifid;

  modport master (
    input  stall, redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, if_valid, if_pc, if_instr, flush_ifid
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, if_valid, if_pc, if_instr, flush_ifid
  );

endinterface

// File: rtl/fetch_buf.sv
// fetch_buf: circular buffer of fetch entries in program order.
//   clk, reset  : clock, asynchronous active-high reset
//   clear       : drop every entry (redirect)
//   alloc       : append an unfilled entry at the tail with pc = alloc_pc
//   fill        : write fill_data into the oldest unfilled entry
//   pop         : retire the head entry
//   head        : current head entry
//   count       : entries allocated (filled or not)
//   pending     : entries still waiting for their instruction word
module fetch_buf #(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        alloc,
  input  logic [fetch_pkg::XLEN-1:0]  alloc_pc,
  input  logic                        fill,
  input  logic [31:0]                 fill_data,
  input  logic                        pop,
  output fetch_pkg::fetch_entry_t     head,
  output logic [CW-1:0]               count,
  output logic [CW-1:0]               pending
);
  import fetch_pkg::*;

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t entries [DEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic [PW-1:0] fill_ptr;

  // Alloc, fill and pop always touch different slots: alloc uses a free slot,
  // fill an unfilled live slot, pop the filled head, so the writes never collide.
  // Pop also clears the filled bit so an empty buffer never shows a stale head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      fill_ptr <= '0;
      count    <= '0;
      pending  <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (clear) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      fill_ptr <= '0;
      count    <= '0;
      pending  <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i].filled <= 1'b0;
    end else begin
      if (alloc) begin
        entries[tail_ptr] <= '{pc: alloc_pc, instr: NOP_INSTR, filled: 1'b0};
        tail_ptr <= tail_ptr + 1'b1;
      end
      if (fill) begin
        entries[fill_ptr].instr  <= fill_data;
        entries[fill_ptr].filled <= 1'b1;
        fill_ptr <= fill_ptr + 1'b1;
      end
      if (pop) begin
        entries[head_ptr].filled <= 1'b0;
        head_ptr <= head_ptr + 1'b1;
      end
      count   <= count + CW'(alloc) - CW'(pop);
      pending <= pending + CW'(alloc) - CW'(fill);
    end
  end

  assign head = entries[head_ptr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage of the RV32 pipeline.
//   clk, reset : clock, asynchronous active-high reset
//   fif        : fetch_if master (pipeline control in, imem request/response, IF/ID outputs)
// Owns the PC, issues in-order word fetches while buffer space remains, discards
// responses that belong to fetches made before a redirect, and presents the oldest
// returned instruction to IF/ID.
module fetch_unit #(
  parameter int              XLEN      = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic     clk,
  input  logic     reset,
  fetch_if.master  fif
);
  import fetch_pkg::*;

  localparam int CW  = $clog2(BUF_DEPTH + 1);
  localparam int CW1 = CW + 1;

  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW:0]     in_flight;
  fetch_entry_t    head;
  logic            grant;
  logic            resp_fill;
  logic            resp_drop;
  logic            head_valid;
  logic            pop;

  fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .clear     (fif.redirect),
    .alloc     (grant),
    .alloc_pc  (pc_q),
    .fill      (resp_fill),
    .fill_data (fif.imem_rdata),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .pending   (outstanding)
  );

  // Requests are held off while reset is asserted so nothing is issued until the
  // first cycle after release.
  assign fif.imem_req  = !reset && !fif.redirect && (count < CW'(BUF_DEPTH));
  assign fif.imem_addr = pc_q;
  assign grant         = fif.imem_req && fif.imem_gnt;

  // Responses pay off older, abandoned fetches first; a response with nothing
  // outstanding at all is a protocol error and is ignored.
  assign resp_drop = fif.imem_rvalid && (drop_cnt != '0);
  assign resp_fill = fif.imem_rvalid && (drop_cnt == '0) && (outstanding != '0) && !fif.redirect;

  assign head_valid = head.filled && (count != '0);
  assign pop        = head_valid && !fif.stall && !fif.redirect;

  assign fif.if_valid   = head_valid && !fif.redirect;
  assign fif.if_pc      = fif.if_valid ? head.pc : '0;
  assign fif.if_instr   = fif.if_valid ? head.instr : NOP_INSTR;
  assign fif.flush_ifid = fif.redirect && !reset;

  // Every fetch still in memory when a redirect hits must be discarded later; a
  // response arriving in the redirect cycle itself already retires one of them.
  assign in_flight = {1'b0, drop_cnt} + {1'b0, outstanding};

  // PC and drop counter. Redirect wins over grant and over any pending drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      drop_cnt <= '0;
    end else if (fif.redirect) begin
      pc_q     <= {fif.redirect_pc[XLEN-1:2], 2'b00};
      drop_cnt <= CW'(in_flight - CW1'(fif.imem_rvalid && (in_flight != '0)));
    end else begin
      if (grant) pc_q <= pc_q + XLEN'(INSTR_BYTES);
      if (resp_drop) drop_cnt <= drop_cnt - 1'b1;
    end
  end

  a_counters_bounded: assert property (@(posedge clk) disable iff (reset)
    (drop_cnt <= CW'(BUF_DEPTH)) && (count <= CW'(BUF_DEPTH)) && (outstanding <= CW'(BUF_DEPTH)));

  a_no_orphan_response: assert property (@(posedge clk) disable iff (reset)
    fif.imem_rvalid |-> ((outstanding != '0) || (drop_cnt != '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// The reference model tracks, per redirect epoch, how many fetches were issued,
// how many responses came back and how many instructions were consumed; expected
// outputs follow from those counts with plain arithmetic. A second instance with
// RESET_PC at the top of the address space checks PC wrap-around.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH   = 2;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  typedef struct {
    logic [31:0] addr;
    int          ep;
    int          due;
  } mem_rsp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  fetch_if #(.XLEN(32)) fif ();
  fetch_if #(.XLEN(32)) wif ();

  fetch_unit #(.XLEN(32), .RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .fif   (fif)
  );

  fetch_unit #(.XLEN(32), .RESET_PC(WRAP_PC), .BUF_DEPTH(DEPTH)) dut_wrap (
    .clk   (clk),
    .reset (reset),
    .fif   (wif)
  );

  always #5 clk = ~clk;

  int vector_count = 0;
  int miscompare_count = 0;

  // Model state for the current epoch.
  int          issued;
  int          filled;
  int          popped;
  int          epoch;
  int          cyc;
  int          lat;
  logic [31:0] start_pc;
  mem_rsp_t    memq[$];

  // Instruction memory contents: a word derived from the address so that
  // if_instr and if_pc are distinguishable.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miscompare_count++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs against
  // the model, then advance the model and the memory at the rising edge.
  task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] rpc, input logic gt);
    logic        exp_req;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        dut_req;
    logic [31:0] dut_addr;
    logic        dut_rvalid;
    mem_rsp_t    rsp;
    @(negedge clk);
    fif.stall       = st;
    fif.redirect    = rd;
    fif.redirect_pc = rpc;
    fif.imem_gnt    = gt;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      fif.imem_rvalid = 1'b1;
      fif.imem_rdata  = mem_word(memq[0].addr);
    end else begin
      fif.imem_rvalid = 1'b0;
      fif.imem_rdata  = $urandom;
    end
    #1;
    exp_req   = !rd && ((issued - popped) < DEPTH);
    exp_valid = !rd && (filled > popped);
    exp_pc    = exp_valid ? start_pc + 32'(4 * popped) : 32'h0;
    exp_instr = exp_valid ? mem_word(exp_pc) : NOP_INSTR;
    checkOutput("flush_ifid", fif.flush_ifid, rd);
    checkOutput("imem_req", fif.imem_req, exp_req);
    if (exp_req) checkOutput("imem_addr", fif.imem_addr, start_pc + 32'(4 * issued));
    checkOutput("if_valid", fif.if_valid, exp_valid);
    checkOutput("if_pc", fif.if_pc, exp_pc);
    checkOutput("if_instr", fif.if_instr, exp_instr);
    dut_req    = fif.imem_req;
    dut_addr   = fif.imem_addr;
    dut_rvalid = fif.imem_rvalid;
    @(posedge clk);
    if (dut_rvalid) begin
      rsp = memq.pop_front();
      if (!rd && rsp.ep == epoch) filled++;
    end
    if (dut_req && gt) memq.push_back('{addr: dut_addr, ep: epoch, due: cyc + lat});
    if (exp_valid && !st) popped++;
    if (exp_req && gt) issued++;
    if (rd) begin
      epoch++;
      issued   = 0;
      filled   = 0;
      popped   = 0;
      start_pc = {rpc[31:2], 2'b00};
    end
    cyc++;
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic doReset();
    @(negedge clk);
    fif.stall       = 1'b0;
    fif.redirect    = 1'b0;
    fif.redirect_pc = 32'h0;
    fif.imem_gnt    = 1'b0;
    fif.imem_rvalid = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("rst_imem_req", fif.imem_req, 1'b0);
    checkOutput("rst_imem_addr", fif.imem_addr, RST_PC);
    checkOutput("rst_if_valid", fif.if_valid, 1'b0);
    checkOutput("rst_if_pc", fif.if_pc, 32'h0);
    checkOutput("rst_if_instr", fif.if_instr, NOP_INSTR);
    checkOutput("rst_flush", fif.flush_ifid, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    memq.delete();
    epoch++;
    issued   = 0;
    filled   = 0;
    popped   = 0;
    start_pc = RST_PC;
  endtask

  initial begin
    issued = 0; filled = 0; popped = 0; epoch = 0; cyc = 0; lat = 1;
    start_pc = RST_PC;
    wif.stall = 1'b0; wif.redirect = 1'b0; wif.redirect_pc = 32'h0;
    wif.imem_gnt = 1'b1; wif.imem_rvalid = 1'b0; wif.imem_rdata = 32'h0;
    fif.stall = 1'b0; fif.redirect = 1'b0; fif.redirect_pc = 32'h0;
    fif.imem_gnt = 1'b0; fif.imem_rvalid = 1'b0; fif.imem_rdata = 32'h0;

    $display("[TB] reset and PC wrap");
    doReset();
    #1;
    checkOutput("wrap_req0", wif.imem_req, 1'b1);
    checkOutput("wrap_addr0", wif.imem_addr, WRAP_PC);
    @(negedge clk); #1;
    checkOutput("wrap_req1", wif.imem_req, 1'b1);
    checkOutput("wrap_addr1", wif.imem_addr, 32'h0000_0000);
    @(negedge clk); #1;
    checkOutput("wrap_req_full", wif.imem_req, 1'b0);

    $display("[TB] streaming fetch");
    lat = 1;
    repeat (8) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    $display("[TB] stall for three cycles");
    repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (6) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    $display("[TB] redirect with fetches outstanding");
    lat = 2;
    repeat (4) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h0000_0100, 1'b1);
    repeat (8) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    lat = 1;
    repeat (4) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    $display("[TB] misaligned redirect target");
    applyStimulus(1'b0, 1'b1, 32'h0000_0103, 1'b1);
    repeat (4) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    $display("[TB] redirect while stalled with a full buffer");
    repeat (4) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h0000_2000, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (4) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    $display("[TB] reset in the middle of fetching");
    repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    doReset();
    repeat (5) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(3) == 0,
                    $urandom_range(15) == 0,
                    $urandom,
                    $urandom_range(3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
    $finish;
  end

endmodule
